// File: rtl/uart_tx_param.sv
// Queued UART transmitter: FIFO feeds a start/data/parity/stop serialiser, TX registered.
// First start bit 2 edges after an idle push; full queue drops TXSTART (TXREADY=0).

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dat,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  // A push while full is dropped even when a pop frees a slot on the same edge.
  assign w_push  = i_push && !o_full && !i_reset;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end
endmodule

module uart_tx_param #(
  parameter int SCYCLE     = 50_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int DATABITS   = 8,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [DATABITS-1:0]         i_txdata,
  input  logic                        i_txstart,
  output logic                        o_txready,
  output logic [$clog2(FIFO_DEPTH):0] o_txlevel,
  output logic                        o_txbusy,
  output logic                        o_txdone,
  output logic                        o_tx
);
  localparam int DIV = SCYCLE / BAUDRATE;
  localparam int BW  = $clog2(DIV);
  localparam int CW  = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]                  r_state;
  logic [BW-1:0]               r_baud;
  logic [CW-1:0]               r_bit;
  logic [DATABITS-1:0]         r_shift;
  logic                        r_par;
  logic                        r_tx;
  logic                        r_avail;
  logic                        w_baud_end;
  logic                        w_last_stop;
  logic                        w_pop;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [DATABITS-1:0]         w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  uart_tx_fifo #(.WIDTH(DATABITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_txstart),
    .i_dat   (i_txdata),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_level (w_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_baud_end  = (r_baud == BW'(DIV - 1));
  assign w_last_stop = (r_state == S_STOP) && w_baud_end && (r_bit == CW'(STOPBITS - 1));
  // Idle start uses the registered queue flag; a frame end chains on the live queue state.
  assign w_pop       = ((r_state == S_IDLE) && r_avail) || (w_last_stop && !w_fifo_empty);

  assign o_tx      = r_tx;
  assign o_txdone  = w_last_stop;
  assign o_txready = !w_fifo_full;
  assign o_txlevel = w_level;
  assign o_txbusy  = (r_state != S_IDLE) || (w_level != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_avail <= 1'b0;
    end else begin
      r_avail <= (w_level != '0);
      r_baud  <= ((r_state == S_IDLE) || w_baud_end) ? '0 : r_baud + BW'(1);
      if (w_pop) begin
        r_state <= S_START;
        r_tx    <= 1'b0;
        r_shift <= w_head;
        r_par   <= ^w_head;
        r_bit   <= '0;
      end else if (w_baud_end) begin
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
          end
          S_DATA: begin
            if (r_bit == CW'(DATABITS - 1)) begin
              r_bit <= '0;
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= (PARITY == 1) ? r_par : ~r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + CW'(1);
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
          S_STOP: begin
            if (r_bit == CW'(STOPBITS - 1)) r_state <= S_IDLE;
            else                            r_bit   <= r_bit + CW'(1);
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench: four UART configurations at DIV=16, per-clock line checks against hand-built frames.
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] txd;
  logic [3:0] tx, ready, busy, done;
  logic [2:0] lvl [4];
  int         vectors = 0;
  int         errors  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.SCYCLE(16), .BAUDRATE(1), .DATABITS(8), .PARITY(0), .STOPBITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .i_clk(clk), .i_reset(rst), .i_txdata(txd), .i_txstart(start[0]), .o_txready(ready[0]),
    .o_txlevel(lvl[0]), .o_txbusy(busy[0]), .o_txdone(done[0]), .o_tx(tx[0]));
  uart_tx_param #(.SCYCLE(16), .BAUDRATE(1), .DATABITS(8), .PARITY(1), .STOPBITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .i_clk(clk), .i_reset(rst), .i_txdata(txd), .i_txstart(start[1]), .o_txready(ready[1]),
    .o_txlevel(lvl[1]), .o_txbusy(busy[1]), .o_txdone(done[1]), .o_tx(tx[1]));
  uart_tx_param #(.SCYCLE(16), .BAUDRATE(1), .DATABITS(8), .PARITY(2), .STOPBITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .i_clk(clk), .i_reset(rst), .i_txdata(txd), .i_txstart(start[2]), .o_txready(ready[2]),
    .o_txlevel(lvl[2]), .o_txbusy(busy[2]), .o_txdone(done[2]), .o_tx(tx[2]));
  uart_tx_param #(.SCYCLE(16), .BAUDRATE(1), .DATABITS(5), .PARITY(0), .STOPBITS(2), .FIFO_DEPTH(4)) u_5n2 (
    .i_clk(clk), .i_reset(rst), .i_txdata(txd[4:0]), .i_txstart(start[3]), .o_txready(ready[3]),
    .o_txlevel(lvl[3]), .o_txbusy(busy[3]), .o_txdone(done[3]), .o_tx(tx[3]));

  task automatic test_reset;
    rst = 1'b1; start = 4'hF; txd = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || ready[i] !== 1'b1 || lvl[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset inst%0d: tx=%b busy=%b done=%b ready=%b level=%0d, required 1 0 0 1 0",
                 i, tx[i], busy[i], done[i], ready[i], lvl[i]);
      end
    end
    rst = 1'b0; start = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (lvl[i] !== 3'd0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ignores_start inst%0d: level=%0d busy=%b, required 0 0", i, lvl[i], busy[i]);
      end
    end
  endtask

  // bits holds the expected line value of frame bit n at position n.
  task automatic test_frame(input int idx, input logic [7:0] data, input logic [15:0] bits,
                            input int nbits, input string name);
    int   flen;
    int   c;
    logic exp_tx;
    flen = nbits * 16;
    @(negedge clk); txd = data; start[idx] = 1'b1;
    for (int k = 0; k <= flen + 4; k++) begin
      @(negedge clk);
      c = k - 1;
      exp_tx = (c >= 1 && c <= flen) ? bits[(c - 1) / 16] : 1'b1;
      vectors++;
      if (tx[idx] !== exp_tx) begin
        errors++;
        $display("FAIL %s tx clk%0d: got %b want %b", name, c, tx[idx], exp_tx);
      end
      vectors++;
      if (done[idx] !== (c == flen)) begin
        errors++;
        $display("FAIL %s txdone clk%0d: got %b want %b", name, c, done[idx], (c == flen));
      end
      vectors++;
      if (busy[idx] !== (k <= flen + 1)) begin
        errors++;
        $display("FAIL %s txbusy clk%0d: got %b want %b", name, c, busy[idx], (k <= flen + 1));
      end
      start[idx] = 1'b0;
      txd = ~data;
    end
  endtask

  task automatic test_fifo;
    int         c, f, b, pops, acc;
    logic [7:0] byte_v;
    logic       exp_tx, exp_done, exp_ready, exp_busy;
    logic [2:0] exp_lvl;
    @(negedge clk); txd = 8'h01; start[0] = 1'b1;
    for (int k = 0; k <= 805; k++) begin
      @(negedge clk);
      c = k - 1;
      exp_tx = 1'b1;
      exp_done = 1'b0;
      if (c >= 1 && c <= 800) begin
        f = (c - 1) / 160;
        b = ((c - 1) % 160) / 16;
        byte_v = 8'(f + 1);
        exp_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte_v[b - 1];
        exp_done = ((c % 160) == 0);
      end
      exp_ready = !(k >= 4 && k <= 161);
      exp_busy  = (k <= 801);
      acc  = (k >= 4) ? 5 : k + 1;
      pops = (k >= 2) ? ((k - 2) / 160 + 1) : 0;
      if (pops > 5) pops = 5;
      exp_lvl = 3'(acc - pops);
      vectors++;
      if (tx[0] !== exp_tx) begin
        errors++; $display("FAIL fifo tx clk%0d: got %b want %b", c, tx[0], exp_tx);
      end
      vectors++;
      if (done[0] !== exp_done) begin
        errors++; $display("FAIL fifo txdone clk%0d: got %b want %b", c, done[0], exp_done);
      end
      vectors++;
      if (ready[0] !== exp_ready) begin
        errors++; $display("FAIL fifo txready edge%0d: got %b want %b", k, ready[0], exp_ready);
      end
      vectors++;
      if (busy[0] !== exp_busy) begin
        errors++; $display("FAIL fifo txbusy edge%0d: got %b want %b", k, busy[0], exp_busy);
      end
      vectors++;
      if (lvl[0] !== exp_lvl) begin
        errors++; $display("FAIL fifo txlevel edge%0d: got %0d want %0d", k, lvl[0], exp_lvl);
      end
      if (k < 5) begin
        txd = 8'(k + 2); start[0] = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk); txd = 8'hA5; start[0] = 1'b1;
    for (int k = 0; k <= 51; k++) begin
      @(negedge clk);
      if (k == 0)      txd = 8'h3C;
      else if (k == 1) txd = 8'h0F;
      else             start[0] = 1'b0;
    end
    vectors++;
    if (lvl[0] !== 3'd2 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_before: level=%0d busy=%b, required 2 1", lvl[0], busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx[0] !== 1'b1 || lvl[0] !== 3'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: tx=%b level=%0d busy=%b done=%b ready=%b, required 1 0 0 0 1",
               tx[0], lvl[0], busy[0], done[0], ready[0]);
    end
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      vectors++;
      if (tx[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cyc%0d: tx=%b done=%b busy=%b, required 1 0 0", k, tx[0], done[0], busy[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 4'h0; txd = 8'h00;
    test_reset();
    test_frame(0, 8'h55, 16'h02AA, 10, "8n1_0x55");
    test_frame(1, 8'h07, 16'h060E, 11, "8e1_0x07");
    test_frame(2, 8'h07, 16'h040E, 11, "8o1_0x07");
    test_frame(3, 8'h1F, 16'h00FE, 8, "5n2_0x1F");
    test_fifo();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
